bsg_nasti_master_arb: RTL

//  Shares the single tunnel request/response port of the NASTI master among
//  NUM_REQ_P requesters (tunnel demux channels) using round-robin arbitration.

---
 rtl/bsg_rocket_pkg.sv | 16 +
 rtl/bsg_nasti_master_arb_if.sv | 48 ++++
 rtl/bsg_nasti_master_arb_tags.sv | 56 +++++
 rtl/bsg_nasti_master_arb.sv | 118 +++++++++++
 4 files changed

// File: rtl/bsg_rocket_pkg.sv
// Shared rocket tunnel types: the demux packet and the NASTI master arbiter FSM state.
package bsg_rocket_pkg;

  typedef struct packed {
    logic [1:0]  chan;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } bsg_tun_dmx_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } bsg_nasti_arb_state_e;

endpackage

// File: rtl/bsg_nasti_master_arb_if.sv
// Requester and NASTI-master handshake bundle around bsg_nasti_master_arb.
// slave = arbiter view, master = surrounding requesters/NASTI master view.
interface bsg_nasti_master_arb_if
  import bsg_rocket_pkg::*;
#(
  parameter int NUM_REQ_P = 4
);

  logic         [NUM_REQ_P-1:0] req_valid_i;
  bsg_tun_dmx_t [NUM_REQ_P-1:0] req_data_i;
  logic         [NUM_REQ_P-1:0] req_rd_i;
  logic         [NUM_REQ_P-1:0] req_yumi_o;
  logic                         mst_req_valid_o;
  bsg_tun_dmx_t                 mst_req_data_o;
  logic                         mst_req_yumi_i;
  logic                         mst_resp_valid_i;
  bsg_tun_dmx_t                 mst_resp_data_i;
  logic                         mst_resp_yumi_o;
  logic         [NUM_REQ_P-1:0] resp_valid_o;
  bsg_tun_dmx_t                 resp_data_o;
  logic         [NUM_REQ_P-1:0] resp_yumi_i;
  logic                         orphan_o;

  modport slave (
    input  req_valid_i, req_data_i, req_rd_i,
    output req_yumi_o,
    output mst_req_valid_o, mst_req_data_o,
    input  mst_req_yumi_i,
    input  mst_resp_valid_i, mst_resp_data_i,
    output mst_resp_yumi_o,
    output resp_valid_o, resp_data_o,
    input  resp_yumi_i,
    output orphan_o
  );

  modport master (
    output req_valid_i, req_data_i, req_rd_i,
    input  req_yumi_o,
    input  mst_req_valid_o, mst_req_data_o,
    output mst_req_yumi_i,
    output mst_resp_valid_i, mst_resp_data_i,
    input  mst_resp_yumi_o,
    input  resp_valid_o, resp_data_o,
    output resp_yumi_i,
    input  orphan_o
  );

endinterface

// File: rtl/bsg_nasti_master_arb_tags.sv
// In-order FIFO of requester indices, one entry per in-flight read.
module bsg_nasti_master_arb_tags #(
  parameter int NUM_REQ_P    = 4,
  parameter int MAX_OUTSTD_P = 8,
  localparam int IDX_W = $clog2(NUM_REQ_P),
  localparam int PTR_W = $clog2(MAX_OUTSTD_P),
  localparam int CNT_W = MAX_OUTSTD_P + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  output logic [IDX_W-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [IDX_W-1:0] mem_r [MAX_OUTSTD_P];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  assign head  = mem_r[rd_ptr_r];
  assign full  = (count_r == CNT_W'(MAX_OUTSTD_P));
  assign empty = (count_r == CNT_W'(0));

  // Tag storage; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_idx;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since depth is a power of 2.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bsg_nasti_master_arb.sv
// Round-robin arbiter sharing the NASTI master tunnel port; read responses return in order.
// Option macro: BSG_NASTI_MASTER_ARB_ORPHAN_DROP_EN (consume responses that have no tag).
module bsg_nasti_master_arb
  import bsg_rocket_pkg::*;
#(
  parameter int NUM_REQ_P    = 4,
  parameter int MAX_OUTSTD_P = 8
) (
  input logic                  clk_i,
  input logic                  reset_i,
  bsg_nasti_master_arb_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ_P);

  bsg_nasti_arb_state_e   state_r;
  logic [IDX_W-1:0]       sel_r;
  logic [IDX_W-1:0]       rr_r;
  logic                   live_r;
  logic                   orphan_r;
  logic                   en_s;
  logic                   grant_s;
  logic [NUM_REQ_P-1:0]   elig_s;
  logic [IDX_W-1:0]       winner_s;
  logic [IDX_W-1:0]       cand_s;
  logic                   any_s;
  logic                   tag_full_s;
  logic                   tag_empty_s;
  logic [IDX_W-1:0]       tag_head_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   orphan_s;
  logic [NUM_REQ_P-1:0]   resp_valid_s;

  // live_r keeps every handshake output low for the cycle following reset
  assign en_s    = live_r & ~reset_i;
  assign grant_s = (state_r == GRANT) & en_s;
  assign elig_s  = bus.req_valid_i & ~(bus.req_rd_i & {NUM_REQ_P{tag_full_s}});

  // Round-robin pick: scan from farthest to nearest so the nearest eligible wins.
  always_comb begin
    winner_s = rr_r;
    any_s    = 1'b0;
    cand_s   = rr_r;
    for (int k = NUM_REQ_P - 1; k >= 0; k--) begin
      cand_s   = IDX_W'((int'(rr_r) + k) % NUM_REQ_P);
      any_s    = any_s | elig_s[cand_s];
      winner_s = elig_s[cand_s] ? cand_s : winner_s;
    end
  end

  // Arbitration FSM plus the sticky orphan flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= IDLE;
      sel_r    <= IDX_W'(0);
      rr_r     <= IDX_W'(0);
      live_r   <= 1'b0;
      orphan_r <= 1'b0;
    end else begin
      live_r <= 1'b1;
      if (orphan_s) begin
        orphan_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (any_s) begin
            sel_r   <= winner_s;
            state_r <= GRANT;
          end
        end
        GRANT: begin
          if (grant_s & bus.mst_req_yumi_i) begin
            rr_r    <= (sel_r == IDX_W'(NUM_REQ_P - 1)) ? IDX_W'(0) : sel_r + IDX_W'(1);
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.mst_req_valid_o = grant_s;
  assign bus.mst_req_data_o  = bus.req_data_i[sel_r];
  assign bus.req_yumi_o      = (grant_s & bus.mst_req_yumi_i) ? (NUM_REQ_P'(1) << sel_r) : '0;
  assign push_s              = grant_s & bus.mst_req_yumi_i & bus.req_rd_i[sel_r];

  // A tag pushed this cycle is not visible until the next, so no bypass path exists.
  assign resp_valid_s = (en_s & ~tag_empty_s & bus.mst_resp_valid_i)
                        ? (NUM_REQ_P'(1) << tag_head_s) : '0;
  assign pop_s        = |(resp_valid_s & bus.resp_yumi_i);
  assign orphan_s     = en_s & tag_empty_s & bus.mst_resp_valid_i;

  assign bus.resp_valid_o = resp_valid_s;
  assign bus.resp_data_o  = bus.mst_resp_data_i;
  assign bus.orphan_o     = orphan_r;

`ifdef BSG_NASTI_MASTER_ARB_ORPHAN_DROP_EN
  assign bus.mst_resp_yumi_o = pop_s | orphan_s;
`else
  assign bus.mst_resp_yumi_o = pop_s;
`endif

  bsg_nasti_master_arb_tags #(
    .NUM_REQ_P    (NUM_REQ_P),
    .MAX_OUTSTD_P (MAX_OUTSTD_P)
  ) tags (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .push     (push_s),
    .push_idx (sel_r),
    .pop      (pop_s),
    .head     (tag_head_s),
    .full     (tag_full_s),
    .empty    (tag_empty_s)
  );

endmodule
